// File: rtl/red_pitaya_adc_spi.sv
// SPI frame engine for the ADC configuration port: serialises one {rw, address, data}
// command per valid/ready handshake and captures the returned byte on read frames.
module red_pitaya_adc_spi #(
  parameter int DIV_HALF = 5,
  parameter int ADR_W    = 7,
  parameter int DAT_W    = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic             cmd_rw_i,
  input  logic [ADR_W-1:0] cmd_adr_i,
  input  logic [DAT_W-1:0] cmd_dat_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [DAT_W-1:0] rd_dat_o,
  output logic             rd_vld_o,
  output logic             spi_cs_o,
  output logic             spi_clk_o,
  output logic             spi_mosi_o,
  input  logic             spi_miso_i
);

  localparam int N  = 1 + ADR_W + DAT_W;
  localparam int BW = $clog2(N + 1);
  localparam logic [7:0]    DIV_LAST   = 8'(DIV_HALF - 1);
  localparam logic [BW-1:0] BIT_LAST   = BW'(N - 1);
  localparam logic [BW-1:0] DATA_FIRST = BW'(1 + ADR_W);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

  state_t           state_r;
  logic [7:0]       div_cnt_r;
  logic [BW-1:0]    bit_cnt_r;
  logic [N-1:0]     frame_r;
  logic [DAT_W-1:0] rx_r;
  logic             rw_r;
  logic             div_end_s;

  assign div_end_s = (div_cnt_r == DIV_LAST);

  // Frame sequencer; spi_clk_o doubles as the low/high phase flag while shifting.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r     <= IDLE;
      div_cnt_r   <= 8'd0;
      bit_cnt_r   <= '0;
      frame_r     <= '0;
      rx_r        <= '0;
      rw_r        <= 1'b0;
      cmd_ready_o <= 1'b1;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      rd_vld_o    <= 1'b0;
      rd_dat_o    <= '0;
      spi_cs_o    <= 1'b1;
      spi_clk_o   <= 1'b1;
      spi_mosi_o  <= 1'b0;
    end else begin
      done_o    <= 1'b0;
      rd_vld_o  <= 1'b0;
      div_cnt_r <= (state_r == IDLE || div_end_s) ? 8'd0 : div_cnt_r + 8'd1;
      case (state_r)
        IDLE: begin
          if (cmd_valid_i) begin
            // Read frames carry zeros in the data field, so MOSI idles low there.
            frame_r     <= {cmd_rw_i, cmd_adr_i, (cmd_rw_i ? {DAT_W{1'b0}} : cmd_dat_i)};
            rw_r        <= cmd_rw_i;
            spi_mosi_o  <= cmd_rw_i;
            spi_cs_o    <= 1'b0;
            cmd_ready_o <= 1'b0;
            busy_o      <= 1'b1;
            state_r     <= SETUP;
          end
        end
        SETUP: begin
          if (div_end_s) begin
            bit_cnt_r <= '0;
            spi_clk_o <= 1'b0;
            state_r   <= SHIFT;
          end
        end
        SHIFT: begin
          if (div_end_s) begin
            if (!spi_clk_o) begin
              spi_clk_o <= 1'b1;
              if (bit_cnt_r >= DATA_FIRST) begin
                rx_r <= (rx_r << 1) | DAT_W'(spi_miso_i);
              end
            end else if (bit_cnt_r == BIT_LAST) begin
              state_r <= HOLD;
            end else begin
              spi_clk_o  <= 1'b0;
              spi_mosi_o <= frame_r[N-2];
              frame_r    <= frame_r << 1;
              bit_cnt_r  <= bit_cnt_r + BW'(1);
            end
          end
        end
        HOLD: begin
          if (div_end_s) begin
            spi_cs_o   <= 1'b1;
            spi_mosi_o <= 1'b0;
            done_o     <= 1'b1;
            rd_vld_o   <= rw_r;
            if (rw_r) begin
              rd_dat_o <= rx_r;
            end
            state_r <= GAP;
          end
        end
        GAP: begin
          if (div_end_s) begin
            cmd_ready_o <= 1'b1;
            busy_o      <= 1'b0;
            state_r     <= IDLE;
          end
        end
        default: begin
          cmd_ready_o <= 1'b1;
          busy_o      <= 1'b0;
          spi_cs_o    <= 1'b1;
          spi_clk_o   <= 1'b1;
          spi_mosi_o  <= 1'b0;
          state_r     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_red_pitaya_adc_spi.sv
// Bench for red_pitaya_adc_spi: table-driven and randomised frames against a word-level
// model, plus back-to-back, mid-frame reset and DIV_HALF=2 sequences.
module tb_red_pitaya_adc_spi;

  localparam int DH       = 5;
  localparam int DH2      = 2;
  localparam int ADR_W    = 7;
  localparam int DAT_W    = 8;
  localparam int N        = 1 + ADR_W + DAT_W;
  localparam int DONE_REL = DH * (2 * N + 2) + 1;
  localparam int RDY_REL  = DH * (2 * N + 3) + 1;

  typedef struct {
    logic       rw;
    logic [6:0] adr;
    logic [7:0] dat;
    logic [7:0] miso;
    logic [15:0] exp_frame;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cmd_valid = 1'b0, cmd_rw = 1'b0;
  logic [6:0] cmd_adr = 7'h00;
  logic [7:0] cmd_dat = 8'h00;
  logic cmd_ready, busy, done, rd_vld, spi_cs, spi_clk, spi_mosi;
  logic spi_miso = 1'b0;
  logic [7:0] rd_dat;

  logic c2_valid = 1'b0, c2_rw = 1'b0;
  logic [6:0] c2_adr = 7'h00;
  logic [7:0] c2_dat = 8'h00;
  logic c2_ready, c2_busy, c2_done, c2_rd_vld, c2_cs, c2_sclk, c2_mosi;
  logic c2_miso = 1'b0;
  logic [7:0] c2_rd_dat;

  int n_chk = 0;
  int n_fail = 0;
  int ecnt = 0;
  logic [7:0] exp_rd = 8'h00;

  // Monitor / ADC model state
  logic prev_cs = 1'b1, prev_sclk = 1'b1;
  logic [15:0] cap_word = 16'h0000;
  int cap_cnt = 0, fall_cnt = 0;
  logic [7:0] miso_byte = 8'h00;
  logic [15:0] frame_q[$];
  int cnt_q[$];

  // b2b CS tracking
  int seen_low, run, min_run, nruns, cs_ready_err;

  red_pitaya_adc_spi #(.DIV_HALF(DH), .ADR_W(ADR_W), .DAT_W(DAT_W)) dut (
    .clk_i(clk), .rst_i(rst), .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
    .cmd_rw_i(cmd_rw), .cmd_adr_i(cmd_adr), .cmd_dat_i(cmd_dat), .busy_o(busy),
    .done_o(done), .rd_dat_o(rd_dat), .rd_vld_o(rd_vld), .spi_cs_o(spi_cs),
    .spi_clk_o(spi_clk), .spi_mosi_o(spi_mosi), .spi_miso_i(spi_miso)
  );

  red_pitaya_adc_spi #(.DIV_HALF(DH2), .ADR_W(ADR_W), .DAT_W(DAT_W)) dut2 (
    .clk_i(clk), .rst_i(rst), .cmd_valid_i(c2_valid), .cmd_ready_o(c2_ready),
    .cmd_rw_i(c2_rw), .cmd_adr_i(c2_adr), .cmd_dat_i(c2_dat), .busy_o(c2_busy),
    .done_o(c2_done), .rd_dat_o(c2_rd_dat), .rd_vld_o(c2_rd_vld), .spi_cs_o(c2_cs),
    .spi_clk_o(c2_sclk), .spi_mosi_o(c2_mosi), .spi_miso_i(c2_miso)
  );

  always #5 clk = ~clk;

  always @(posedge clk) ecnt <= ecnt + 1;

  // ADC-side model: serves the read byte on SCLK falls, records MOSI on SCLK rises.
  always @(negedge clk) begin
    int b;
    if (!spi_cs && prev_cs) begin
      cap_word = 16'h0000; cap_cnt = 0; fall_cnt = 0; spi_miso = 1'b0;
    end
    if (!spi_cs && prev_sclk && !spi_clk) begin
      fall_cnt++;
      b = fall_cnt - 1;
      if (b >= 1 + ADR_W && b < N) spi_miso = miso_byte[N - 1 - b];
      else spi_miso = 1'b0;
    end
    if (!spi_cs && !prev_sclk && spi_clk) begin
      cap_word = {cap_word[14:0], spi_mosi};
      cap_cnt++;
    end
    if (spi_cs && !prev_cs) begin
      frame_q.push_back(cap_word);
      cnt_q.push_back(cap_cnt);
    end
    prev_cs = spi_cs;
    prev_sclk = spi_clk;
  end

  function automatic logic [15:0] model_frame(input logic rw, input logic [6:0] adr,
                                              input logic [7:0] dat);
    int w;
    w = (rw ? 32768 : 0) + int'(adr) * 256 + (rw ? 0 : int'(dat));
    return 16'(w);
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", nm, act, exp);
    end
  endtask

  task automatic track_cs();
    if (spi_cs) run++;
    else begin
      if (seen_low != 0 && run > 0) begin
        nruns++;
        if (run < min_run) min_run = run;
      end
      seen_low = 1;
      run = 0;
    end
    if (!spi_cs && cmd_ready) cs_ready_err++;
  endtask

  task automatic run_cmd(input vec_t v);
    int done_at = -1, vld_at = -1, rdy_at = -1, ndone = 0, nvld = 0, inv_err = 0, w = 0;
    logic [7:0] rd_at_done = 8'h00;
    frame_q.delete(); cnt_q.delete();
    miso_byte = v.miso;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_rw = v.rw; cmd_adr = v.adr; cmd_dat = v.dat;
    while (!cmd_ready && w < 400) begin @(negedge clk); w++; end
    check("ready_before_accept", cmd_ready, 1);
    @(negedge clk);
    for (int rel = 1; rel <= RDY_REL; rel++) begin
      if (rel > 1) @(negedge clk);
      if (rel == 1) begin
        check("cs_low_cycle1", spi_cs, 0);
        check("mosi_msb_cycle1", spi_mosi, v.rw);
        cmd_valid = 1'b0; cmd_rw = ~v.rw; cmd_adr = ~v.adr; cmd_dat = ~v.dat;
      end
      if (busy === cmd_ready) inv_err++;
      if (done) begin ndone++; done_at = rel; rd_at_done = rd_dat; end
      if (rd_vld) begin nvld++; vld_at = rel; end
      if (cmd_ready && rdy_at < 0) rdy_at = rel;
    end
    if (v.rw) exp_rd = v.miso;
    check("frame_count", frame_q.size(), 1);
    check("mosi_frame", (frame_q.size() > 0) ? frame_q[0] : 16'hxxxx, v.exp_frame);
    check("sclk_rises_cs_low", (cnt_q.size() > 0) ? cnt_q[0] : -1, N);
    check("done_cycle", done_at, DONE_REL);
    check("done_pulses", ndone, 1);
    check("rd_vld_pulses", nvld, v.rw ? 1 : 0);
    if (v.rw) check("rd_vld_cycle", vld_at, DONE_REL);
    check("rd_dat_at_done", rd_at_done, exp_rd);
    check("rd_dat_after", rd_dat, exp_rd);
    check("ready_cycle", rdy_at, RDY_REL);
    check("busy_eq_not_ready", inv_err, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, n_chk=%0d", n_chk);
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t vecs[8];
    vec_t b2b[4];
    vec_t after_rst;
    int err, w, toggles, pend, idx, rdy_at, done_at, rl;
    int acc_t[4];
    logic lvl, prev;
    logic [15:0] word;
    int runs[$];
    int exp_runs[$];

    vecs[0] = '{1'b0, 7'h02, 8'h01, 8'h00, 16'h0201};
    vecs[1] = '{1'b1, 7'h03, 8'h5A, 8'hA5, 16'h8300};
    vecs[2] = '{1'b0, 7'h7F, 8'hFF, 8'h00, 16'h7FFF};
    vecs[3] = '{1'b1, 7'h7F, 8'hFF, 8'h5A, 16'hFF00};
    for (int i = 4; i < 8; i++) begin
      vecs[i].rw   = 1'($urandom_range(0, 1));
      vecs[i].adr  = 7'($urandom);
      vecs[i].dat  = 8'($urandom);
      vecs[i].miso = 8'($urandom);
      vecs[i].exp_frame = model_frame(vecs[i].rw, vecs[i].adr, vecs[i].dat);
    end
    b2b[0] = '{1'b0, 7'h01, 8'h00, 8'h00, 16'h0100};
    b2b[1] = '{1'b0, 7'h02, 8'h01, 8'h00, 16'h0201};
    b2b[2] = '{1'b0, 7'h03, 8'h02, 8'h00, 16'h0302};
    b2b[3] = '{1'b0, 7'h04, 8'h00, 8'h00, 16'h0400};
    after_rst = '{1'b1, 7'h11, 8'h00, 8'h3C, 16'h9100};

    // Reset and idle
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_ready", cmd_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_rd_vld", rd_vld, 0);
    check("rst_rd_dat", rd_dat, 0);
    check("rst_cs", spi_cs, 1);
    check("rst_sclk", spi_clk, 1);
    check("rst_mosi", spi_mosi, 0);
    err = 0; toggles = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if ({cmd_ready, busy, done, rd_vld, rd_dat, spi_cs, spi_mosi} !== {1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0}) err++;
      if (spi_clk !== 1'b1) toggles++;
    end
    check("idle_outputs", err, 0);
    check("idle_sclk_toggles", toggles, 0);

    // Table-driven single frames
    for (int i = 0; i < 8; i++) run_cmd(vecs[i]);

    // Back-to-back writes with cmd_valid held
    frame_q.delete(); cnt_q.delete();
    seen_low = 0; run = 0; min_run = 9999; nruns = 0; cs_ready_err = 0;
    pend = 0; idx = 0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_rw = b2b[0].rw; cmd_adr = b2b[0].adr; cmd_dat = b2b[0].dat;
    for (int t = 0; t < 1000 && idx < 4; t++) begin
      if (pend != 0) begin
        idx++; pend = 0;
        if (idx < 4) begin cmd_rw = b2b[idx].rw; cmd_adr = b2b[idx].adr; cmd_dat = b2b[idx].dat; end
        else cmd_valid = 1'b0;
      end
      if (idx < 4 && cmd_ready) begin acc_t[idx] = ecnt; pend = 1; end
      track_cs();
      @(negedge clk);
    end
    w = 0;
    while (!(cmd_ready && frame_q.size() == 4) && w < 400) begin track_cs(); @(negedge clk); w++; end
    check("b2b_accepts", idx, 4);
    for (int i = 1; i < 4; i++) check("b2b_accept_spacing", acc_t[i] - acc_t[i-1], RDY_REL);
    check("b2b_frame_count", frame_q.size(), 4);
    for (int i = 0; i < 4; i++)
      check("b2b_frame", (frame_q.size() > i) ? frame_q[i] : 16'hxxxx, b2b[i].exp_frame);
    check("b2b_cs_gaps", nruns, 3);
    check("b2b_cs_gap_min", (min_run >= DH) ? 1 : 0, 1);
    check("b2b_cs_low_while_ready", cs_ready_err, 0);
    check("b2b_rd_dat_kept", rd_dat, exp_rd);

    // Reset in the middle of a read frame
    miso_byte = 8'hA5;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_rw = 1'b1; cmd_adr = 7'h03; cmd_dat = 8'h00;
    w = 0;
    while (!cmd_ready && w < 400) begin @(negedge clk); w++; end
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (79) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_rd = 8'h00;
    check("mid_rst_cs", spi_cs, 1);
    check("mid_rst_sclk", spi_clk, 1);
    check("mid_rst_mosi", spi_mosi, 0);
    check("mid_rst_ready", cmd_ready, 1);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_rd_dat", rd_dat, exp_rd);
    err = 0;
    for (int i = 0; i < 150; i++) begin
      @(negedge clk);
      if (done || rd_vld || !spi_cs) err++;
    end
    check("mid_rst_no_done", err, 0);
    check("mid_rst_rd_dat_kept", rd_dat, exp_rd);
    run_cmd(after_rst);

    // DIV_HALF=2 instance
    exp_runs.push_back(DH2);
    for (int k = 0; k < N; k++) begin
      exp_runs.push_back(DH2);
      exp_runs.push_back((k == N - 1) ? 2 * DH2 : DH2);
    end
    @(negedge clk);
    c2_valid = 1'b1; c2_rw = 1'b0; c2_adr = 7'h15; c2_dat = 8'hC3;
    w = 0;
    while (!c2_ready && w < 400) begin @(negedge clk); w++; end
    @(negedge clk);
    c2_valid = 1'b0;
    rdy_at = -1; done_at = -1; rl = 0; lvl = 1'b1; prev = 1'b1; word = 16'h0000;
    for (int rel = 1; rel <= DH2 * (2 * N + 3) + 1; rel++) begin
      if (rel > 1) @(negedge clk);
      if (!c2_cs) begin
        if (rl > 0 && c2_sclk == lvl) rl++;
        else begin
          if (rl > 0) runs.push_back(rl);
          lvl = c2_sclk; rl = 1;
        end
        if (!prev && c2_sclk) word = {word[14:0], c2_mosi};
      end else if (rl > 0) begin
        runs.push_back(rl); rl = 0;
      end
      prev = c2_sclk;
      if (c2_done && done_at < 0) done_at = rel;
      if (c2_ready && rdy_at < 0) rdy_at = rel;
    end
    check("dh2_cycles_to_ready", rdy_at - 1, DH2 * (2 * N + 3));
    check("dh2_done_cycle", done_at, DH2 * (2 * N + 2) + 1);
    check("dh2_mosi_frame", word, model_frame(1'b0, 7'h15, 8'hC3));
    check("dh2_phase_count", runs.size(), exp_runs.size());
    err = 0;
    for (int i = 0; i < exp_runs.size(); i++)
      if (i >= runs.size() || runs[i] != exp_runs[i]) err++;
    check("dh2_phase_lengths", err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
